// File: rtl/crc_pkg.sv
// Shared types and the bit-serial CRC reference loop for the streaming CRC engine.
package crc_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [31:0] CRC16_8005     = 32'h0000_8005;
    localparam logic [31:0] CRC16_1021     = 32'h0000_1021;
    localparam logic [31:0] CRC32_04C11DB7 = 32'h04C1_1DB7;

    localparam int MAX_CRC_W  = 32;
    localparam int MAX_DATA_W = 128;

    // Absorbs the low nbits of data, highest of those bits first.
    function automatic logic [MAX_CRC_W-1:0] crc_bits(
        input logic [MAX_CRC_W-1:0]  crc,
        input logic [MAX_DATA_W-1:0] data,
        input int                    nbits,
        input int                    crc_w = 16,
        input logic [MAX_CRC_W-1:0]  poly  = CRC16_8005
    );
        logic [MAX_CRC_W-1:0] c;
        logic [MAX_CRC_W:0]   m33;
        logic [MAX_CRC_W-1:0] mask;
        logic                 fb;
        m33  = (33'd1 << crc_w) - 33'd1;
        mask = m33[MAX_CRC_W-1:0];
        c    = crc & mask;
        for (int i = MAX_DATA_W - 1; i >= 0; i--) begin
            if (i < nbits) begin
                fb = c[5'(crc_w - 1)] ^ data[7'(i)];
                c  = ((c << 1) & mask) ^ (fb ? poly : '0);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_word_step.sv
// Combinational one-word CRC update; absorbs the top nbytes bytes (0 or oversize = full word).
module crc_word_step
    import crc_pkg::*;
#(
    parameter int               CRC_W  = 16,
    parameter logic [CRC_W-1:0] POLY   = 16'h8005,
    parameter int               DATA_W = 32,
    parameter int               NB_W   = $clog2(DATA_W/8) + 1
) (
    input  logic [CRC_W-1:0]  crc_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [NB_W-1:0]   nbytes_i,
    output logic [CRC_W-1:0]  crc_o
);
    localparam int NBYTES = DATA_W / 8;

    int                    nbits;
    logic [MAX_DATA_W-1:0] data_al;
    logic [MAX_CRC_W-1:0]  crc_nx;

    always_comb begin
        nbits = DATA_W;
        if (nbytes_i != '0 && int'(nbytes_i) <= NBYTES)
            nbits = int'(nbytes_i) * 8;
        // Right-align the absorbed bytes so the loop sees them as the low nbits.
        data_al = MAX_DATA_W'(data_i >> (DATA_W - nbits));
        crc_nx  = crc_bits(MAX_CRC_W'(crc_i), data_al, nbits, CRC_W, MAX_CRC_W'(POLY));
        crc_o   = crc_nx[CRC_W-1:0];
    end

endmodule

// File: rtl/crc_stream_engine.sv
// Framed streaming CRC generator with valid/ready on both sides and a held result.
// Optional residue compare (RESIDUE parameter, out_match port) under CRC_STREAM_CHECK_EN.
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h8005,
    parameter logic [CRC_W-1:0] INIT    = 16'hFFFF,
    parameter logic [CRC_W-1:0] XOR_OUT = 16'h0000,
    parameter int               DATA_W  = 32,
    parameter int               NB_W    = $clog2(DATA_W/8) + 1
`ifdef CRC_STREAM_CHECK_EN
    ,
    parameter logic [CRC_W-1:0] RESIDUE = '0
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic [NB_W-1:0]   in_nbytes,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CRC_W-1:0]  out_crc
`ifdef CRC_STREAM_CHECK_EN
    ,
    output logic              out_match
`endif
);
    state_e           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d, crc_step;
    logic [NB_W-1:0]  nbytes_eff;

    // Byte count only matters on the closing beat.
    assign nbytes_eff = in_last ? in_nbytes : '0;

    crc_word_step #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .DATA_W(DATA_W),
        .NB_W  (NB_W)
    ) u_step (
        .crc_i   (crc_q),
        .data_i  (in_data),
        .nbytes_i(nbytes_eff),
        .crc_o   (crc_step)
    );

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE, BUSY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    crc_d   = crc_step;
                    state_d = in_last ? DONE : BUSY;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                    crc_d   = INIT;
                end
            end
            default: begin
                state_d = IDLE;
                crc_d   = INIT;
            end
        endcase
        if (clr) begin
            state_d = IDLE;
            crc_d   = INIT;
        end
    end

    assign out_crc = out_valid ? (crc_q ^ XOR_OUT) : '0;

`ifdef CRC_STREAM_CHECK_EN
    assign out_match = out_valid && (crc_q == RESIDUE);
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            crc_q   <= INIT;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// Bench: three engines (CRC-16/8005, CRC-32, CRC-16/1021) driven in lockstep from one stream.
module tb_crc_stream_engine;

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, in_last, out_ready;
    logic [31:0] in_data;
    logic [2:0]  in_nbytes;
    logic        in_ready_a, in_ready_b, in_ready_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic [15:0] out_crc_a, out_crc_c;
    logic [31:0] out_crc_b;
`ifdef CRC_STREAM_CHECK_EN
    logic        out_match_a, out_match_b, out_match_c;
`endif

    always #5 clk = ~clk;

    crc_stream_engine u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .in_nbytes(in_nbytes),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_crc(out_crc_a)
`ifdef CRC_STREAM_CHECK_EN
        , .out_match(out_match_a)
`endif
    );

    crc_stream_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .in_nbytes(in_nbytes),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_crc(out_crc_b)
`ifdef CRC_STREAM_CHECK_EN
        , .out_match(out_match_b)
`endif
    );

    crc_stream_engine #(.POLY(16'h1021)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_data(in_data), .in_last(in_last), .in_nbytes(in_nbytes),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_crc(out_crc_c)
`ifdef CRC_STREAM_CHECK_EN
        , .out_match(out_match_c)
`endif
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] frm_w [8];
    int          frm_nw;
    logic [2:0]  frm_nb;

    typedef struct {
        logic [31:0] w0, w1, w2;
        int          nw;
        logic [2:0]  nb;
        int          gap;
        logic [15:0] ea;
        logic [31:0] eb;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Frame-level reference: gather the absorbed bytes, then run the textbook bit loop.
    function automatic logic [31:0] ref_crc(input int cw, input logic [31:0] poly,
                                            input logic [31:0] init, input logic [31:0] xo);
        logic [31:0] c, mask;
        logic [7:0]  bytes [$];
        int          n;
        mask = (cw == 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
        for (int k = 0; k < frm_nw; k++) begin
            n = 4;
            if (k == frm_nw - 1 && frm_nb != 0 && frm_nb <= 4) n = int'(frm_nb);
            for (int j = 0; j < n; j++) bytes.push_back(frm_w[k][31-8*j -: 8]);
        end
        c = init;
        foreach (bytes[i])
            for (int t = 7; t >= 0; t--)
                c = (c[cw-1] ^ bytes[i][t]) ? (((c << 1) & mask) ^ poly) : ((c << 1) & mask);
        return c ^ xo;
    endfunction

    task automatic load_frame(input vec_t v);
        frm_w[0] = v.w0; frm_w[1] = v.w1; frm_w[2] = v.w2;
        frm_nw = v.nw; frm_nb = v.nb;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready_a && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("in_ready_timeout", 32'(in_ready_a), 32'd1);
    endtask

    task automatic beat(input logic [31:0] d, input logic last, input logic [2:0] nb);
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = last; in_nbytes = nb;
        wait_ready();
    endtask

    task automatic send_frame(input int gap);
        for (int k = 0; k < frm_nw; k++) begin
            if (k > 0)
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    in_valid = 1'b0; in_data = $urandom; in_last = 1'b1;
                end
            if (k == frm_nw - 1) chk("no_early_valid", 32'(out_valid_a), 32'd0);
            beat(frm_w[k], k == frm_nw - 1, (k == frm_nw - 1) ? frm_nb : 3'($urandom));
        end
        @(negedge clk);
        in_valid = 1'b0; in_data = $urandom; in_last = 1'($urandom);
    endtask

    task automatic accept(input int hold, input logic [15:0] ea);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; in_data = $urandom; in_last = 1'b1;
            @(negedge clk);
            chk("hold_crc_a", 32'(out_crc_a), 32'(ea));
            chk("hold_in_ready", 32'(in_ready_a), 32'd0);
            chk("hold_out_valid", 32'(out_valid_a), 32'd1);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_out_valid", 32'(out_valid_a), 32'd0);
        chk("release_in_ready", 32'(in_ready_a), 32'd1);
        chk("release_out_crc", 32'(out_crc_a), 32'd0);
    endtask

    task automatic run_frame(input string name, input int gap, input int hold,
                             input logic [15:0] ea, input logic [31:0] eb, input logic [15:0] ec);
        send_frame(gap);
        chk({name, " latency_valid_a"}, 32'(out_valid_a), 32'd1);
        chk({name, " latency_valid_b"}, 32'(out_valid_b), 32'd1);
        chk({name, " latency_valid_c"}, 32'(out_valid_c), 32'd1);
        chk({name, " done_in_ready"}, 32'(in_ready_a), 32'd0);
        chk({name, " crc_a"}, 32'(out_crc_a), 32'(ea));
        chk({name, " crc_b"}, out_crc_b, eb);
        chk({name, " crc_c"}, 32'(out_crc_c), 32'(ec));
        accept(hold, ea);
    endtask

    task automatic run_model(input string name, input int gap, input int hold);
        run_frame(name, gap, hold,
                  16'(ref_crc(16, 32'h8005, 32'hFFFF, 32'h0)),
                  ref_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF),
                  16'(ref_crc(16, 32'h1021, 32'hFFFF, 32'h0)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; in_nbytes = '0; out_ready = 1'b0;

        tbl[0] = '{32'h31323334, 32'h35363738, 32'h39000000, 3, 3'd1, 0, 16'hAEE7, 32'hFC891918, 16'h29B1};
        tbl[1] = '{32'h31323334, 32'h35363738, 32'h39FFFFFF, 3, 3'd1, 3, 16'hAEE7, 32'hFC891918, 16'h29B1};
        tbl[2] = '{32'hDEADBEEF, 32'h0, 32'h0, 1, 3'd0, 0, 16'h0, 32'h0, 16'h0};
        tbl[3] = '{32'h01020304, 32'hA5A5A5A5, 32'h0, 2, 3'd4, 1, 16'h0, 32'h0, 16'h0};
        tbl[4] = '{32'hCAFEF00D, 32'h0, 32'h0, 1, 3'd7, 0, 16'h0, 32'h0, 16'h0};
        tbl[5] = '{32'h3132FFFF, 32'h0, 32'h0, 1, 3'd2, 2, 16'h0, 32'h0, 16'h0};
        for (int i = 2; i < 6; i++) begin
            load_frame(tbl[i]);
            tbl[i].ea = 16'(ref_crc(16, 32'h8005, 32'hFFFF, 32'h0));
            tbl[i].eb = ref_crc(32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF);
            tbl[i].ec = 16'(ref_crc(16, 32'h1021, 32'hFFFF, 32'h0));
        end

        repeat (3) @(negedge clk);
        chk("reset in_ready_a", 32'(in_ready_a), 32'd1);
        chk("reset out_valid_a", 32'(out_valid_a), 32'd0);
        chk("reset out_crc_a", 32'(out_crc_a), 32'd0);
        chk("reset out_crc_b", out_crc_b, 32'd0);
        rst_n = 1'b0;

        foreach (tbl[i]) begin
            load_frame(tbl[i]);
            run_frame($sformatf("vec%0d", i), tbl[i].gap, 0, tbl[i].ea, tbl[i].eb, tbl[i].ec);
        end

        // Result held 5 cycles while a beat is offered, then a fresh frame must start from INIT.
        load_frame(tbl[0]);
        run_frame("stall", 0, 5, 16'hAEE7, 32'hFC891918, 16'h29B1);
        run_frame("after_stall", 0, 0, 16'hAEE7, 32'hFC891918, 16'h29B1);

        // Abort after two beats; the closing beat offered with clr is dropped.
        beat(32'h31323334, 1'b0, 3'd0);
        beat(32'h35363738, 1'b0, 3'd0);
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b1; in_data = 32'h39000000; in_last = 1'b1; in_nbytes = 3'd1;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("clr no_out_valid", 32'(out_valid_a), 32'd0);
            @(negedge clk);
        end
        run_frame("after_clr", 0, 0, 16'hAEE7, 32'hFC891918, 16'h29B1);

        // clr while the result is waiting in DONE.
        send_frame(0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_done out_valid", 32'(out_valid_a), 32'd0);
        chk("clr_done in_ready", 32'(in_ready_a), 32'd1);
        run_frame("after_clr_done", 0, 0, 16'hAEE7, 32'hFC891918, 16'h29B1);

        // Asynchronous reset mid-frame, then in DONE.
        beat(32'h31323334, 1'b0, 3'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        #1 chk("async_rst in_ready", 32'(in_ready_a), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        run_frame("after_rst_mid", 0, 0, 16'hAEE7, 32'hFC891918, 16'h29B1);
        send_frame(0);
        #2 rst_n = 1'b1;
        #1 chk("async_rst_done out_valid", 32'(out_valid_a), 32'd0);
        chk("async_rst_done out_crc", out_crc_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        run_frame("after_rst_done", 0, 0, 16'hAEE7, 32'hFC891918, 16'h29B1);

`ifdef CRC_STREAM_CHECK_EN
        frm_w[0] = 32'h31323334; frm_w[1] = 32'h35363738; frm_w[2] = 32'h39AEE700;
        frm_nw = 3; frm_nb = 3'd3;
        send_frame(0);
        chk("residue out_crc_a", 32'(out_crc_a), 32'd0);
        chk("residue match", 32'(out_match_a), 32'd1);
        accept(0, 16'h0);
        chk("residue match_idle", 32'(out_match_a), 32'd0);
        frm_w[1] = 32'h35363739;
        send_frame(0);
        chk("residue flip_match", 32'(out_match_a), 32'd0);
        accept(0, 16'(ref_crc(16, 32'h8005, 32'hFFFF, 32'h0)));
`endif

        for (int r = 0; r < 40; r++) begin
            frm_nw = int'($urandom_range(1, 5));
            for (int k = 0; k < frm_nw; k++) frm_w[k] = $urandom;
            frm_nb = 3'($urandom);
            run_model($sformatf("rand%0d", r), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crc_stream_engine.md
Name: crc_stream_engine

Overview:
- Parametrised streaming CRC generator: successor to the fixed 16-bit/32-bit-data CRC block, generalising CRC width, polynomial, init/xor-out and data width.
- Adds frame delimiting, a partial last word (byte count), a valid/ready handshake on both sides and a held result.
- Sits between the switch ingress/egress datapath and the frame-check logic; one instance per port.

Parameters:
- CRC_W, 16, CRC width in bits (8..32)
- POLY, 16'h8005, generator polynomial without x^CRC_W term (default 1+x^2+x^15+x^16)
- INIT, 16'hFFFF, register value at start of each frame
- XOR_OUT, 16'h0000, XORed onto final CRC before output
- DATA_W, 32, input word width; multiple of 8, 8..128
- NB_W, $clog2(DATA_W/8)+1, width of in_nbytes

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous abort: drop current frame, return to IDLE
- in_valid  in  1  input beat valid
- in_ready  out  1  engine accepts beat
- in_data  in  DATA_W  data word, MSB-first byte order
- in_last  in  1  beat is last of frame
- in_nbytes  in  NB_W  valid bytes on last beat, MSB-aligned; 0 = full word
- out_valid  out  1  final CRC available
- out_ready  in  1  consumer accepts CRC
- out_crc  out  CRC_W  final CRC (after XOR_OUT)

Behaviour:
- Bit order: each word is processed serially from bit DATA_W-1 down to bit 0. Per bit: fb = crc[CRC_W-1]^d; crc = (crc<<1) ^ (fb ? POLY : 0).
- The whole word is unrolled combinationally; one beat per clock, no bubbles.
- Beat transfer = in_valid & in_ready.
- Reset (rst_n=1, async): state IDLE, crc reg = INIT, in_ready=1, out_valid=0, out_crc=0.
- States:
  - IDLE: crc=INIT; in_ready=1. On a transfer, absorb the beat. in_last=1 -> DONE, else -> BUSY.
  - BUSY: in_ready=1. Absorb each transferred beat; on a transfer with in_last=1 -> DONE.
  - DONE: in_ready=0, out_valid=1, out_crc = crc^XOR_OUT, held stable until out_ready. On out_ready -> IDLE and crc=INIT (next beat accepted the following cycle).
- Partial word: in_nbytes applies only when in_last=1; only the top in_nbytes bytes are absorbed and the lower bytes are ignored. in_nbytes>DATA_W/8 is treated as full. in_nbytes is ignored when in_last=0.
- Latency: last beat accepted in cycle N -> out_valid high in cycle N+1.
- in_valid=0 in BUSY: crc holds and state stays BUSY (frames may stall indefinitely).
- clr has priority over everything in any state: next cycle state IDLE, crc=INIT, out_valid=0. A beat presented in the same cycle as clr is discarded.
- Async reset mid-frame or in DONE: immediate return to reset values; partial CRC lost.
- in_data, in_last and in_nbytes are don't-care when in_valid=0.

Optional Feature:
- Macro: CRC_STREAM_CHECK_EN.
- With the macro: extra parameter RESIDUE (default 0) and output port out_match (1 bit).
  - out_match = (pre-XOR_OUT crc == RESIDUE); valid when out_valid=1, 0 otherwise.
  - Used on receive frames that carry their CRC at the tail.
- Without the macro: no RESIDUE, no out_match port and no compare logic.

Decomposition:
- Package crc_pkg holds:
  - state enum {IDLE, BUSY, DONE};
  - named polynomial constants (CRC16_8005, CRC16_1021, CRC32_04C11DB7);
  - a function crc_bits(crc, data, nbits) implementing the serial loop, usable by the bench as a reference model.
- Sub-module crc_word_step (combinational, parameters CRC_W/POLY/DATA_W): inputs crc, data, nbytes; output next crc. The top instantiates it once.

Test Plan:
- Defaults, frame "123456789" as 0x31323334, 0x35363738, 0x39000000 with last=1, nbytes=1 -> out_crc=16'hAEE7, out_valid one cycle after the last beat.
- CRC_W=32, POLY=32'h04C11DB7, INIT=XOR_OUT=32'hFFFFFFFF, same frame -> out_crc=32'hFC891918.
- POLY=16'h1021, same frame, in_valid gaps of 3 cycles between beats -> 16'h29B1, unaffected by gaps.
- out_ready held 0 for 5 cycles in DONE -> out_crc stable, in_ready=0, no beat absorbed; frame sent right after acceptance is computed from INIT and yields 16'hAEE7 again.
- clr asserted after the 2nd beat, then the full frame is resent -> no out_valid for the aborted frame, result 16'hAEE7.
- With CRC_STREAM_CHECK_EN: frame "123456789" followed by CRC bytes AE E7 (last word 0x39AEE700, nbytes=3) -> pre-XOR crc 0, out_match=1. Flip one data bit -> out_match=0.
